dict_field3_loader: RTL and testbench

Boot-time loader that fills the field-3 dictionary of the decompression path from a packed table in memory. Fetches 32-bit words holding two 15-bit entries each, buffers them in a small FIFO, and drives the dictionary's `write_enable`/`write_val` port as one unbroken burst of 2**KEY_WIDTH writes. The burst must be unbroken because the dictionary resets its write index whenever `write_enable` drops.

---
 rtl/dict_loader_pkg.sv | 23 ++
 rtl/dict_loader_fifo.sv | 65 ++++++
 rtl/dict_field3_loader.sv | 217 +++++++++++++++++++++
 tb/tb_dict_field3_loader.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dict_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dict_loader_pkg
// Description : Shared constants for the field-3 dictionary loader: packed
//               word layout and FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package dict_loader_pkg;

  localparam int WORD_WIDTH       = 32;
  localparam int ENTRIES_PER_WORD = 2;
  localparam int ENTRY_A_LSB      = 0;
  localparam int ENTRY_B_LSB      = 16;

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_fetch = 3'd1;
  localparam logic [2:0] c_st_burst = 3'd2;
  localparam logic [2:0] c_st_drain = 3'd3;
  localparam logic [2:0] c_st_done  = 3'd4;
  localparam logic [2:0] c_st_error = 3'd5;

endpackage
`default_nettype wire

// File: rtl/dict_loader_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dict_loader_fifo
// Description : Synchronous prefetch FIFO with flush, occupancy count and
//               full/empty flags; asynchronous active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
module dict_loader_fifo #(
  parameter int WIDTH = 30,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int c_ptr_w = $clog2(DEPTH);

  typedef logic [c_ptr_w-1:0] ptr_t;
  typedef logic [c_ptr_w:0]   cnt_t;

  logic [WIDTH-1:0] r_mem [DEPTH];
  ptr_t             r_wr_ptr;
  ptr_t             r_rd_ptr;
  cnt_t             r_count;
  logic             w_push;
  logic             w_pop;

  assign full     = (r_count == cnt_t'(DEPTH));
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign pop_data = r_mem[r_rd_ptr];
  assign w_push   = push && !full;
  assign w_pop    = pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ptr_t'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + ptr_t'(1);
      r_count <= r_count + cnt_t'(w_push) - cnt_t'(w_pop);
    end
  end

  // Storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/dict_field3_loader.sv
`default_nettype none
// ============================================================================
// Module      : dict_field3_loader
// Description : Boot-time loader streaming the packed field-3 table into the
//               dictionary as one unbroken write burst. Burst restart on FIFO
//               underflow is enabled by defining DICT_LOADER_RETRY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dict_field3_loader
  import dict_loader_pkg::*;
#(
  parameter int KEY_WIDTH  = 8,
  parameter int VAL_WIDTH  = 15,
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_RETRY  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  rd_req_valid,
  input  logic                  rd_req_ready,
  output logic [ADDR_WIDTH-1:0] rd_req_addr,
  input  logic                  rd_rsp_valid,
  input  logic [WORD_WIDTH-1:0] rd_rsp_data,
  output logic                  write_enable,
  output logic [VAL_WIDTH-1:0]  write_val,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            retry_cnt
);

  localparam int c_num_words = (2 ** KEY_WIDTH) / ENTRIES_PER_WORD;
  localparam int c_cnt_w     = $clog2(FIFO_DEPTH) + 1;
  localparam int c_pair_w    = 2 * VAL_WIDTH;

  typedef logic [KEY_WIDTH-1:0]  key_t;
  typedef logic [c_cnt_w-1:0]    cnt_t;
  typedef logic [c_cnt_w:0]      sum_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  localparam key_t c_all_words = key_t'(c_num_words);
  localparam key_t c_last_word = key_t'(c_num_words - 1);
  localparam sum_t c_depth     = sum_t'(FIFO_DEPTH);

  logic [2:0]          r_state;
  addr_t               r_base;
  key_t                r_words_req;
  key_t                r_words_rcv;
  key_t                r_words_wr;
  cnt_t                r_outstanding;
  cnt_t                r_stale;
  logic                r_phase;
  logic                r_we;
  logic [VAL_WIDTH-1:0] r_wval;
  logic                r_done;
  logic                r_err;
`ifdef DICT_LOADER_RETRY_EN
  localparam logic [1:0] c_max_retry = 2'(MAX_RETRY);
  logic [1:0]          r_retry;
`endif

  logic                w_issue_state;
  logic                w_credit_ok;
  logic                w_req_fire;
  logic                w_rsp_keep;
  logic                w_start_ok;
  logic                w_underflow;
  logic                w_flush;
  logic                w_pop;
  logic [c_pair_w-1:0] w_push_data;
  logic [c_pair_w-1:0] w_head;
  cnt_t                w_fifo_count;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic                w_unused_rsp_pad;

  assign w_issue_state = (r_state == c_st_fetch) || (r_state == c_st_burst);
  assign w_credit_ok   = (sum_t'(w_fifo_count) + sum_t'(r_outstanding)) < c_depth;
  assign rd_req_valid  = w_issue_state && (r_words_req != c_all_words) && w_credit_ok;
  assign w_req_fire    = rd_req_valid && rd_req_ready;
  assign rd_req_addr   = r_base + (addr_t'(r_words_req) << 2);

  // Responses to requests issued before the current load began are dropped.
  assign w_rsp_keep    = rd_rsp_valid && w_issue_state && (r_stale == '0);
  assign w_start_ok    = start && ((r_state == c_st_idle) || (r_state == c_st_done) ||
                                   (r_state == c_st_error));
  assign w_underflow   = (r_state == c_st_burst) && !r_phase && w_fifo_empty;
  assign w_flush       = w_start_ok || w_underflow;
  assign w_pop         = (r_state == c_st_burst) && r_phase;

  assign w_push_data      = {rd_rsp_data[ENTRY_B_LSB +: VAL_WIDTH],
                             rd_rsp_data[ENTRY_A_LSB +: VAL_WIDTH]};
  assign w_unused_rsp_pad = ^rd_rsp_data;

  dict_loader_fifo #(
    .WIDTH (c_pair_w),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_rsp_keep),
    .push_data (w_push_data),
    .pop       (w_pop),
    .flush     (w_flush),
    .pop_data  (w_head),
    .count     (w_fifo_count),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= c_st_idle;
      r_base        <= '0;
      r_words_req   <= '0;
      r_words_rcv   <= '0;
      r_words_wr    <= '0;
      r_outstanding <= '0;
      r_stale       <= '0;
      r_phase       <= 1'b0;
      r_we          <= 1'b0;
      r_wval        <= '0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
`ifdef DICT_LOADER_RETRY_EN
      r_retry       <= 2'd0;
`endif
    end else begin
      r_we          <= 1'b0;
      r_outstanding <= r_outstanding + cnt_t'(w_req_fire) - cnt_t'(rd_rsp_valid);

      if (w_start_ok)
        r_stale <= r_outstanding - cnt_t'(rd_rsp_valid);
      else if (rd_rsp_valid && (r_stale != '0))
        r_stale <= r_stale - cnt_t'(1);

      if (w_flush) begin
        r_words_req <= '0;
        r_words_rcv <= '0;
        r_words_wr  <= '0;
        r_phase     <= 1'b0;
      end else begin
        if (w_req_fire) r_words_req <= r_words_req + key_t'(1);
        if (w_rsp_keep) r_words_rcv <= r_words_rcv + key_t'(1);
      end

      case (r_state)
        c_st_idle, c_st_done, c_st_error: begin
          // done lags the DONE state by one cycle so it follows the last write.
          if (r_state == c_st_done) r_done <= 1'b1;
          if (w_start_ok) begin
            r_state <= c_st_fetch;
            r_base  <= base_addr;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
`ifdef DICT_LOADER_RETRY_EN
            r_retry <= 2'd0;
`endif
          end
        end
        c_st_fetch: begin
          if (w_fifo_full || (r_words_rcv == c_all_words)) r_state <= c_st_burst;
        end
        c_st_burst: begin
          if (!r_phase) begin
            if (w_fifo_empty) begin
`ifdef DICT_LOADER_RETRY_EN
              if (r_retry == c_max_retry) begin
                r_state <= c_st_error;
                r_err   <= 1'b1;
              end else begin
                r_state <= c_st_drain;
                r_retry <= r_retry + 2'd1;
              end
`else
              r_state <= c_st_error;
              r_err   <= 1'b1;
`endif
            end else begin
              r_we    <= 1'b1;
              r_wval  <= w_head[VAL_WIDTH-1:0];
              r_phase <= 1'b1;
            end
          end else begin
            r_we       <= 1'b1;
            r_wval     <= w_head[c_pair_w-1:VAL_WIDTH];
            r_phase    <= 1'b0;
            r_words_wr <= r_words_wr + key_t'(1);
            if (r_words_wr == c_last_word) r_state <= c_st_done;
          end
        end
`ifdef DICT_LOADER_RETRY_EN
        c_st_drain: begin
          if (r_outstanding == '0) r_state <= c_st_fetch;
        end
`endif
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign write_enable = r_we;
  assign write_val    = r_wval;
  assign done         = r_done;
  assign err          = r_err;
  assign busy         = w_issue_state || (r_state == c_st_drain);
`ifdef DICT_LOADER_RETRY_EN
  assign retry_cnt    = r_retry;
`else
  assign retry_cnt    = 2'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dict_field3_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_dict_field3_loader
// Description : Directed self-checking bench for dict_field3_loader with a
//               variable-latency in-order memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dict_field3_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic        rd_req_valid;
  logic        rd_req_ready;
  logic [31:0] rd_req_addr;
  logic        rd_rsp_valid = 1'b0;
  logic [31:0] rd_rsp_data  = '0;
  logic        write_enable;
  logic [14:0] write_val;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  retry_cnt;

  int tests = 0;
  int fails = 0;
  int lat = 1;
  int cyc = 0;
  logic [31:0] mem_base = '0;
  int test_id = 0;
  int mon_id = 0;
  int writes = 0, bad = 0, run = 0, maxrun = 0;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rsp_t;
  rsp_t q[$];

  dict_field3_loader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .base_addr    (base_addr),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_req_addr  (rd_req_addr),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_data  (rd_rsp_data),
    .write_enable (write_enable),
    .write_val    (write_val),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .retry_cnt    (retry_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] ent(input int i);
    logic [31:0] t;
    t = (i * 97 + 13) ^ (i << 7);
    return t[14:0];
  endfunction

  // Padding bits set to 1 so a mis-sliced entry shows up in the data.
  function automatic logic [31:0] word_of(input int w);
    return {1'b1, ent(2 * w + 1), 1'b1, ent(2 * w)};
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      q.delete();
      rd_rsp_valid = 1'b0;
      rd_rsp_data  = '0;
    end else begin
      if (rd_req_valid && rd_req_ready)
        q.push_back('{word_of(int'((rd_req_addr - mem_base) >> 2)), cyc + lat});
      if (q.size() > 0 && q[0].due <= cyc) begin
        rd_rsp_valid = 1'b1;
        rd_rsp_data  = q[0].data;
        void'(q.pop_front());
      end else begin
        rd_rsp_valid = 1'b0;
        rd_rsp_data  = '0;
      end
    end
  end

  // Dictionary model: write index restarts whenever write_enable drops.
  always @(negedge clk) begin
    if (mon_id != test_id) begin
      mon_id = test_id;
      writes = 0; bad = 0; run = 0; maxrun = 0;
    end
    if (write_enable === 1'b1) begin
      if (write_val !== ent(run)) bad++;
      run++;
      writes++;
      if (run > maxrun) maxrun = run;
    end else begin
      run = 0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [31:0] b);
    start     = 1'b1;
    base_addr = b;
    tick();
    start     = 1'b0;
    base_addr = 32'hDEAD_0000;
  endtask

  task automatic wait_end(input int budget, output bit ok, output logic prev_we);
    logic last_we;
    ok      = 1'b0;
    last_we = write_enable;
    prev_we = 1'b0;
    for (int i = 0; i < budget; i++) begin
      prev_we = last_we;
      tick();
      if (done || err) begin
        ok = 1'b1;
        break;
      end
      last_we = write_enable;
    end
  endtask

  initial begin
    bit   ok;
    logic pwe;

    reset        = 1'b1;
    start        = 1'b0;
    base_addr    = '0;
    rd_req_ready = 1'b1;
    tick();
    tick();
    check("reset write_enable", write_enable, 0);
    check("reset write_val", write_val, 0);
    check("reset done", done, 0);
    check("reset err", err, 0);
    check("reset busy", busy, 0);
    check("reset rd_req_valid", rd_req_valid, 0);
    check("reset rd_req_addr", rd_req_addr, 0);
    check("reset retry_cnt", retry_cnt, 0);
    reset = 1'b0;
    tick();

    // Full load, latency 1.
    test_id = 1; lat = 1; mem_base = 32'h0000_1000;
    pulse_start(32'h0000_1000);
    check("first req valid", rd_req_valid, 1);
    check("first req addr", rd_req_addr, 32'h0000_1000);
    check("busy after start", busy, 1);
    wait_end(2000, ok, pwe);
    check("load1 finished", ok, 1);
    check("load1 done", done, 1);
    check("load1 err", err, 0);
    check("load1 retry_cnt", retry_cnt, 0);
    check("load1 writes", writes, 256);
    check("load1 data errors", bad, 0);
    check("load1 contiguous run", maxrun, 256);
    check("load1 we before done", pwe, 1);
    check("load1 we low at done", write_enable, 0);
    check("load1 busy at done", busy, 0);
    repeat (5) tick();
    check("load1 no request after done", rd_req_valid, 0);

    // start during the burst must be ignored.
    test_id = 2; mem_base = 32'h0000_4000;
    pulse_start(32'h0000_4000);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (run == 50) begin ok = 1'b1; break; end
    end
    check("reached write 50", ok, 1);
    pulse_start(32'h0000_9000);
    wait_end(2000, ok, pwe);
    check("start-in-burst finished", ok, 1);
    check("start-in-burst done", done, 1);
    check("start-in-burst writes", writes, 256);
    check("start-in-burst data errors", bad, 0);
    check("start-in-burst run", maxrun, 256);

    // Asynchronous reset at write 100, then a fresh load.
    test_id = 3; mem_base = 32'h0000_2000;
    pulse_start(32'h0000_2000);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (run == 100) begin ok = 1'b1; break; end
    end
    check("reached write 100", ok, 1);
    reset = 1'b1;
    #1;
    check("mid-load reset outputs",
          {write_enable, write_val, done, err, busy, rd_req_valid, retry_cnt, rd_req_addr}, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    test_id = 4;
    pulse_start(32'h0000_2000);
    wait_end(2000, ok, pwe);
    check("post-reset load finished", ok, 1);
    check("post-reset done", done, 1);
    check("post-reset writes", writes, 256);
    check("post-reset data errors", bad, 0);

    // Latency 20 with an 8-word FIFO: every burst underflows after 16 writes.
    test_id = 5; lat = 20; mem_base = 32'h0001_0000;
    pulse_start(32'h0001_0000);
    check("slow load busy", busy, 1);
    wait_end(5000, ok, pwe);
    check("slow load finished", ok, 1);
    check("slow load err", err, 1);
    check("slow load done", done, 0);
    check("slow load busy", busy, 0);
    check("slow load longest run", maxrun, 16);
`ifdef DICT_LOADER_RETRY_EN
    check("slow load retry_cnt", retry_cnt, 3);
    check("slow load writes", writes, 64);
`else
    check("slow load retry_cnt", retry_cnt, 0);
    check("slow load writes", writes, 16);
`endif
    check("slow load data errors", bad, 0);
    repeat (60) tick();

    // Restart from ERROR with a fast memory.
    test_id = 6; lat = 1; mem_base = 32'h0002_0000;
    pulse_start(32'h0002_0000);
    check("restart clears err", err, 0);
    wait_end(2000, ok, pwe);
    check("restart finished", ok, 1);
    check("restart done", done, 1);
    check("restart writes", writes, 256);
    check("restart data errors", bad, 0);

`ifdef DICT_LOADER_RETRY_EN
    // One underflow, then memory speeds up and the retry completes.
    test_id = 7; lat = 20; mem_base = 32'h0003_0000;
    pulse_start(32'h0003_0000);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (retry_cnt == 2'd1) begin ok = 1'b1; break; end
    end
    check("first underflow seen", ok, 1);
    lat = 1;
    wait_end(3000, ok, pwe);
    check("retry load finished", ok, 1);
    check("retry load done", done, 1);
    check("retry load err", err, 0);
    check("retry load retry_cnt", retry_cnt, 1);
    check("retry load writes", writes, 16 + 256);
    check("retry load run", maxrun, 256);
    check("retry load data errors", bad, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
